// File: rtl/mul4_seq.sv
// mul4_seq: sequential 4x4 unsigned shift-and-add multiplier.
//
// The product is built one multiplier bit per cycle over four CALC cycles.
// A one-cycle DONE state presents the registered product, and then the block
// returns to IDLE. Each CALC addition goes through a single 4-bit ripple
// adder (sum4).
//
// Ports (mul4_seq):
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset
//   start  in   1  request to multiply a by b, sampled in IDLE only
//   a      in   4  multiplicand, unsigned
//   b      in   4  multiplier, unsigned
//   busy   out  1  high while in CALC
//   done   out  1  one-cycle pulse; p is final while done=1
//   p      out  8  registered product, changes only on entry to DONE or reset
//
// Optional feature: define MUL4_EARLY_EXIT_EN to send a zero-operand request
// straight from IDLE to DONE with p=0. CALC is skipped, so busy never rises.
// When the macro is undefined, every request takes the full four CALC cycles.

// 4-bit ripple-carry adder.
module sum4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [4:0] carry;

  always_comb begin
    carry[0] = c_in;
    for (int i = 0; i < 4; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    c_out = carry[4];
  end

endmodule

module mul4_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] p
);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e     state_q, state_d;

  logic [3:0] m_q;      // multiplicand
  logic [3:0] q_q;      // multiplier, shifted right as product bits arrive
  logic [3:0] acc_q;    // accumulator A
  logic       c_q;      // adder carry C
  logic [2:0] count_q;  // remaining CALC steps
  logic [7:0] p_q;

  logic [3:0] add_sum;
  logic       add_cout;
  logic       c_step;
  logic [3:0] a_step;
  logic       calc_last;
  logic       early_exit;

  sum4 u_sum4 (
    .a     (acc_q),
    .b     (m_q),
    .c_in  (1'b0),
    .sum   (add_sum),
    .c_out (add_cout)
  );

`ifdef MUL4_EARLY_EXIT_EN
  assign early_exit = (a == 4'd0) || (b == 4'd0);
`else
  assign early_exit = 1'b0;
`endif

  // Add-or-pass step. The shift writes a 0 into C on every step, so C is
  // always 0 at this point. Passing {C,A} therefore gives the same value as
  // {0,A}.
  always_comb begin
    if (q_q[0]) begin
      {c_step, a_step} = {add_cout, add_sum};
    end else begin
      {c_step, a_step} = {c_q, acc_q};
    end
  end

  assign calc_last = (count_q == 3'd1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = early_exit ? StDone : StCalc;
        end
      end
      StCalc: begin
        if (calc_last) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StCalc:  busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign p = p_q;

  // Datapath: {C,A,Q} shifts right by one after each add-or-pass step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q     <= 4'd0;
      q_q     <= 4'd0;
      acc_q   <= 4'd0;
      c_q     <= 1'b0;
      count_q <= 3'd0;
      p_q     <= 8'h00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            m_q     <= a;
            q_q     <= b;
            acc_q   <= 4'd0;
            c_q     <= 1'b0;
            count_q <= 3'd4;
            if (early_exit) begin
              p_q <= 8'h00;
            end
          end
        end
        StCalc: begin
          c_q     <= 1'b0;
          acc_q   <= {c_step, a_step[3:1]};
          q_q     <= {a_step[0], q_q[3:1]};
          count_q <= count_q - 3'd1;
          if (calc_last) begin
            // Shifted {A,Q} after the final step
            p_q <= {c_step, a_step, q_q[3:1]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul4_seq.sv
// Directed testbench for mul4_seq. The bench drives inputs on the falling
// edge and samples outputs on the falling edge. The n-th falling edge after
// the accepting rising edge shows the state that edge left behind: CALC for
// n = 0..3 and DONE at n = 4. With MUL4_EARLY_EXIT_EN and a zero operand,
// DONE appears at n = 0.
module tb_mul4_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] p;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [7:0] last_p;

  mul4_seq u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for a done pulse, sampled on falling edges, with a bounded budget.
  task automatic wait_done(input string tag, output int at);
    at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check({tag, "_timeout"}, done, 1);
  endtask

  // One full operation with cycle-accurate busy/done/p checks.
  task automatic do_mul(input logic [3:0] ai, input logic [3:0] bi, input string tag);
    int         lat;
    logic [7:0] expp;
    expp = 8'(ai) * 8'(bi);
    lat  = 4;
`ifdef MUL4_EARLY_EXIT_EN
    if (ai == 4'd0 || bi == 4'd0) lat = 0;
`endif
    @(negedge clk);
    start = 1'b1;
    a     = ai;
    b     = bi;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 4'($urandom);
    b     = 4'($urandom);
    for (int n = 0; n <= lat; n++) begin
      @(negedge clk);
      check({tag, "_busy"}, busy, (n < lat) ? 1 : 0);
      check({tag, "_done"}, done, (n == lat) ? 1 : 0);
      if (n < lat) check({tag, "_p_hold"}, p, last_p);
      else check({tag, "_p"}, p, expp);
    end
    last_p = expp;
    @(negedge clk);
    check({tag, "_done_1cyc"}, done, 0);
    check({tag, "_p_idle"}, p, expp);
  endtask

  initial begin
    int t1, t2, extra;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = 4'd0;
    b      = 4'd0;
    last_p = 8'h00;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_p", p, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Full-range product
    do_mul(4'd15, 4'd15, "m15x15");

    // Back-to-back with start held high: new operation every 6 cycles
    @(negedge clk);
    start = 1'b1;
    a     = 4'd9;
    b     = 4'd6;
    wait_done("b2b1", t1);
    check("b2b1_p", p, 8'h36);
    a = 4'd1;
    b = 4'd1;
    wait_done("b2b2", t2);
    check("b2b2_p", p, 8'h01);
    check("b2b_spacing", t2 - t1, 6);
    start  = 1'b0;
    last_p = 8'h01;
    @(negedge clk);

    // start during CALC is ignored
    @(negedge clk);
    start = 1'b1;
    a     = 4'd5;
    b     = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a     = 4'd2;
    b     = 4'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign", t1);
    check("ign_p", p, 8'h0F);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("ign_one_done", extra, 0);
    last_p = 8'h0F;

    // Reset mid-CALC aborts the operation
    @(negedge clk);
    start = 1'b1;
    a     = 4'd7;
    b     = 4'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("abort_busy_pre", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_p", p, 8'h00);
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("abort_quiet", extra, 0);
    rst_n  = 1'b1;
    last_p = 8'h00;
    do_mul(4'd2, 4'd3, "post_rst");

    // Zero operand: latency depends on MUL4_EARLY_EXIT_EN
    do_mul(4'd0, 4'd11, "zero_a");

    // Exhaustive operand sweep
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        do_mul(4'(i), 4'(j), $sformatf("ex_%0d_%0d", i, j));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
